ysyx_24110006_clint: RTL

Read-only core-local timer slave for the `ysyx_24110006` core. It sits on crossbar port 2, which carries the CLINT/RTC read traffic. It holds a free-running 64-bit `mtime` counter and returns it as two 32-bit words over an AXI4-Lite read channel. A snapshot of the high half, taken when the low word is read, makes a low-then-high read pair coherent.

---
 rtl/ysyx_24110006_clint_pkg.sv | 8 +
 rtl/ysyx_24110006_clint_timer.sv | 23 ++
 rtl/ysyx_24110006_clint.sv | 53 +++++
 3 files changed

// File: rtl/ysyx_24110006_clint_pkg.sv
// ysyx_24110006_clint_pkg: shared constants and FSM state type for the CLINT timer slave
package ysyx_24110006_clint_pkg;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] RTC_BASE_SIM = 32'ha0000048;
  localparam logic [31:0] RTC_BASE_SOC = 32'h02000000;
  typedef enum logic {IDLE, RESP} state_e;
endpackage

// File: rtl/ysyx_24110006_clint_timer.sv
// ysyx_24110006_clint_timer: prescaled free-running 64-bit mtime counter
module ysyx_24110006_clint_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [63:0] o_mtime
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          tick;
  always_comb begin
    tick      = div_cnt_q == DW'(TICK_DIV - 1);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    mtime_d   = tick ? mtime_q + 64'd1 : mtime_q;
  end
  always_ff @(posedge i_clock) begin
    div_cnt_q <= i_reset ? '0 : div_cnt_d;
    mtime_q   <= i_reset ? '0 : mtime_d;
  end
  assign o_mtime = mtime_q;
endmodule

// File: rtl/ysyx_24110006_clint.sv
// ysyx_24110006_clint: read-only AXI4-Lite mtime slave with coherent low/high snapshot
module ysyx_24110006_clint
  import ysyx_24110006_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RTC_BASE_SIM,
  parameter int          TICK_DIV  = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  output logic [1:0]  o_axi_rresp,
  input  logic        i_axi_rready
);
  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d, hi_snap_q, hi_snap_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        snap_vld_q, snap_vld_d;
  logic [63:0] mtime;
  logic        ar_hs, r_hs, is_lo, is_hi;
  ysyx_24110006_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .o_mtime(mtime)
  );
  always_comb begin
    ar_hs      = state_q == IDLE && i_axi_arvalid;
    r_hs       = state_q == RESP && i_axi_rready;
    is_lo      = i_axi_araddr == BASE_ADDR;
    is_hi      = i_axi_araddr == BASE_ADDR + 32'd4;
    state_d    = ar_hs ? RESP : r_hs ? IDLE : state_q;
    rdata_d    = !ar_hs ? rdata_q : is_lo ? mtime[31:0] :
                 is_hi ? (snap_vld_q ? hi_snap_q : mtime[63:32]) : 32'd0;
    rresp_d    = !ar_hs ? rresp_q : (is_lo || is_hi) ? RESP_OKAY : RESP_SLVERR;
    // Low read freezes the high word so a following high read is coherent.
    hi_snap_d  = ar_hs && is_lo ? mtime[63:32] : hi_snap_q;
    snap_vld_d = ar_hs && is_lo ? 1'b1 : ar_hs && is_hi ? 1'b0 : snap_vld_q;
  end
  always_ff @(posedge i_clock) begin
    state_q    <= i_reset ? IDLE : state_d;
    rdata_q    <= i_reset ? '0 : rdata_d;
    rresp_q    <= i_reset ? RESP_OKAY : rresp_d;
    hi_snap_q  <= i_reset ? '0 : hi_snap_d;
    snap_vld_q <= i_reset ? 1'b0 : snap_vld_d;
  end
  assign o_axi_arready = state_q == IDLE;
  assign o_axi_rvalid  = state_q == RESP;
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;
endmodule
